fp_align_pipe: RTL and testbench

- Parametrised two-stage exponent-compare and mantissa-align pipeline for the extreme-low-precision FP MAC datapath.
- Takes two sign/exponent/mantissa operands and selects the larger exponent.
- Right-shifts the smaller operand's mantissa, with hidden bit and guard bits, and produces a sticky bit.
- Sits between operand fetch and the mantissa add/multiply stage; uses a valid/ready handshake so the MAC can stall.

---
 rtl/fp_align_pipe.sv | 150 +++++++++++++++
 tb/tb_fp_align_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_align_pipe.sv
// fp_align_pipe: two-stage exponent compare and mantissa alignment for the
// low-precision FP MAC. Stage 1 picks the larger exponent and builds the
// extended mantissas. Stage 2 right-shifts the smaller mantissa and forms the
// sticky bit. Both stages advance together under one valid/ready enable, so a
// downstream stall freezes the whole pipe.
module fp_align_pipe #(
    parameter int EXP_W  = 3,
    parameter int MAN_W  = 2,
    parameter int GRD_W  = 2,
    parameter int HIDDEN = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   s_a,
    input  logic                   s_b,
    input  logic [EXP_W-1:0]       e_a,
    input  logic [EXP_W-1:0]       e_b,
    input  logic [MAN_W-1:0]       m_a,
    input  logic [MAN_W-1:0]       m_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W:0]         e_out,
    output logic [MAN_W+GRD_W:0]   mx,
    output logic [MAN_W+GRD_W:0]   my,
    output logic                   sx,
    output logic                   sy,
    output logic                   a_ge_b,
    output logic                   sticky
);

    localparam int AW = 1 + MAN_W + GRD_W;

    // Pipeline advance enable: move whenever the output slot is free or draining.
    logic en_s;
    assign en_s     = !out_valid || out_ready;
    assign in_ready = en_s;

    // Stage 1 combinational results
    logic          hid_a_s, hid_b_s;
    logic [AW-1:0] ext_a_s, ext_b_s;
    logic          a_ge_s;
    logic [AW-1:0] big_s, small_s;
    logic          s_big_s, s_small_s;
    logic [EXP_W-1:0] diff_s, emax_s;
    logic [EXP_W:0]   emax_inc_s;

    // Stage 1 registers
    logic             v1_r;
    logic [EXP_W-1:0] diff1_r;
    logic [AW-1:0]    big1_r, small1_r;
    logic             s_big1_r, s_small1_r;
    logic [EXP_W:0]   emax1_r;
    logic             a_ge1_r;

    // Stage 2 combinational results
    logic [AW-1:0] mask_s;
    logic [AW-1:0] my_s;
    logic          sticky_s;

    // Build extended mantissas and order the operands by exponent (tie goes to A).
    always_comb begin
        hid_a_s = (HIDDEN != 32'sd0) && (e_a != {EXP_W{1'b0}});
        hid_b_s = (HIDDEN != 32'sd0) && (e_b != {EXP_W{1'b0}});
        ext_a_s = {hid_a_s, m_a, {GRD_W{1'b0}}};
        ext_b_s = {hid_b_s, m_b, {GRD_W{1'b0}}};
        a_ge_s  = (e_a >= e_b);
        if (a_ge_s) begin
            big_s     = ext_a_s;
            small_s   = ext_b_s;
            s_big_s   = s_a;
            s_small_s = s_b;
            diff_s    = e_a - e_b;
            emax_s    = e_a;
        end else begin
            big_s     = ext_b_s;
            small_s   = ext_a_s;
            s_big_s   = s_b;
            s_small_s = s_a;
            diff_s    = e_b - e_a;
            emax_s    = e_b;
        end
        // One extra bit so the increment of the largest exponent never wraps.
        emax_inc_s = {1'b0, emax_s} + {{EXP_W{1'b0}}, 1'b1};
    end

    // Stage 1 register bank: capture ordered operands when the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r       <= 1'b0;
            diff1_r    <= {EXP_W{1'b0}};
            big1_r     <= {AW{1'b0}};
            small1_r   <= {AW{1'b0}};
            s_big1_r   <= 1'b0;
            s_small1_r <= 1'b0;
            emax1_r    <= {(EXP_W+1){1'b0}};
            a_ge1_r    <= 1'b0;
        end else if (en_s) begin
            v1_r       <= in_valid;
            diff1_r    <= diff_s;
            big1_r     <= big_s;
            small1_r   <= small_s;
            s_big1_r   <= s_big_s;
            s_small1_r <= s_small_s;
            emax1_r    <= emax_inc_s;
            a_ge1_r    <= a_ge_s;
        end else begin
            v1_r       <= v1_r;
        end
    end

    // Align the smaller mantissa; shifts of AW or more flush it entirely into sticky.
    always_comb begin
        mask_s = ~({AW{1'b1}} << diff1_r);
        if (int'(diff1_r) >= AW) begin
            my_s     = {AW{1'b0}};
            sticky_s = |small1_r;
        end else begin
            my_s     = small1_r >> diff1_r;
            sticky_s = |(small1_r & mask_s);
        end
    end

    // Stage 2 register bank: drives every output of the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            e_out     <= {(EXP_W+1){1'b0}};
            mx        <= {AW{1'b0}};
            my        <= {AW{1'b0}};
            sx        <= 1'b0;
            sy        <= 1'b0;
            a_ge_b    <= 1'b0;
            sticky    <= 1'b0;
        end else if (en_s) begin
            out_valid <= v1_r;
            e_out     <= emax1_r;
            mx        <= big1_r;
            my        <= my_s;
            sx        <= s_big1_r;
            sy        <= s_small1_r;
            a_ge_b    <= a_ge1_r;
            sticky    <= sticky_s;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_fp_align_pipe.sv
// Testbench for fp_align_pipe: directed vectors with hand-computed results,
// back-to-back streams under fixed and random backpressure checked through a
// scoreboard fed by an arithmetic reference model, and an asynchronous reset
// applied while operands are in flight.
module tb_fp_align_pipe;

    localparam int EXP_W  = 3;
    localparam int MAN_W  = 2;
    localparam int GRD_W  = 2;
    localparam int HIDDEN = 1;
    localparam int AW     = 1 + MAN_W + GRD_W;
    localparam int RW     = EXP_W + 1 + 2 * AW + 4;

    typedef logic [RW-1:0] res_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready;
    logic             s_a, s_b;
    logic [EXP_W-1:0] e_a, e_b;
    logic [MAN_W-1:0] m_a, m_b;
    logic             out_valid, out_ready;
    logic [EXP_W:0]   e_out;
    logic [AW-1:0]    mx, my;
    logic             sx, sy, a_ge_b, sticky;

    res_t sb_q[$];
    res_t pend_exp;
    res_t held;
    bit   prev_stall;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fp_align_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .GRD_W(GRD_W), .HIDDEN(HIDDEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .s_a(s_a), .s_b(s_b), .e_a(e_a), .e_b(e_b), .m_a(m_a), .m_b(m_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .e_out(e_out), .mx(mx), .my(my), .sx(sx), .sy(sy),
        .a_ge_b(a_ge_b), .sticky(sticky)
    );

    function automatic res_t obs_vec();
        return {e_out, mx, my, sx, sy, a_ge_b, sticky};
    endfunction

    // Reference model written with integer arithmetic (division/modulo for shifts).
    function automatic res_t model(bit sa, int ea, int ma, bit sb, int eb, int mb);
        int xa, xb, big, sml, d, myv, eo;
        bit age, st, sxe, sye;
        res_t r;
        xa  = ((HIDDEN != 0 && ea != 0) ? (1 << (MAN_W + GRD_W)) : 0) + ma * (1 << GRD_W);
        xb  = ((HIDDEN != 0 && eb != 0) ? (1 << (MAN_W + GRD_W)) : 0) + mb * (1 << GRD_W);
        age = (ea >= eb);
        if (age) begin
            big = xa; sml = xb; d = ea - eb; eo = ea + 1; sxe = sa; sye = sb;
        end else begin
            big = xb; sml = xa; d = eb - ea; eo = eb + 1; sxe = sb; sye = sa;
        end
        if (d >= AW) begin
            myv = 0;
            st  = (sml != 0);
        end else begin
            myv = sml / (1 << d);
            st  = (sml % (1 << d)) != 0;
        end
        r = {eo[EXP_W:0], big[AW-1:0], myv[AW-1:0], sxe, sye, age, st};
        return r;
    endfunction

    task automatic check(string tag, res_t obs, res_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(bit sa, int ea, int ma, bit sb, int eb, int mb, res_t e);
        s_a      = sa;
        s_b      = sb;
        e_a      = ea[EXP_W-1:0];
        e_b      = eb[EXP_W-1:0];
        m_a      = ma[MAN_W-1:0];
        m_b      = mb[MAN_W-1:0];
        pend_exp = e;
        in_valid = 1'b1;
    endtask

    // One clock: sample transfers on the falling edge, then step past the rising edge.
    task automatic tick(output bit acc);
        res_t cur;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) sb_q.push_back(pend_exp);
        cur = obs_vec();
        if (out_valid && !out_ready) begin
            check("stall_in_ready", in_ready, 1'b0);
            if (prev_stall) check("stall_hold", cur, held);
            held       = cur;
            prev_stall = 1'b1;
        end else begin
            prev_stall = 1'b0;
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) check("unexpected_out", out_valid, 1'b0);
            else check("result", cur, sb_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    // Single operand with out_ready high: checks the two-cycle latency then the value.
    task automatic one_op(string tag, bit sa, int ea, int ma, bit sb, int eb, int mb, res_t e);
        bit acc;
        out_ready = 1'b1;
        set_op(sa, ea, ma, sb, eb, mb, e);
        tick(acc);
        check({tag, "_accept"}, acc, 1'b1);
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 1'b0);
        tick(acc);
        check({tag, "_lat2"}, out_valid, 1'b1);
        tick(acc);
        check({tag, "_drained"}, sb_q.size(), 0);
    endtask

    // Stream n random operands; rnd=0 stalls cycles 2..4, rnd=1 toggles out_ready randomly.
    task automatic stream(string tag, int n, bit rnd);
        int ea[32], eb[32], ma[32], mb[32];
        bit sa[32], sb[32];
        int idx = 0;
        int cyc = 0;
        bit acc;
        for (int i = 0; i < n; i++) begin
            ea[i] = int'($urandom_range(0, 7));
            eb[i] = int'($urandom_range(0, 7));
            ma[i] = int'($urandom_range(0, 3));
            mb[i] = int'($urandom_range(0, 3));
            sa[i] = 1'($urandom_range(0, 1));
            sb[i] = 1'($urandom_range(0, 1));
        end
        while ((idx < n || sb_q.size() != 0) && cyc < 400) begin
            if (idx < n)
                set_op(sa[idx], ea[idx], ma[idx], sb[idx], eb[idx], mb[idx],
                       model(sa[idx], ea[idx], ma[idx], sb[idx], eb[idx], mb[idx]));
            else
                in_valid = 1'b0;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 2 && cyc <= 4);
            tick(acc);
            if (acc) idx++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_accepted"}, idx, n);
        check({tag, "_drained"}, sb_q.size(), 0);
    endtask

    initial begin
        bit acc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; prev_stall = 1'b0;
        s_a = 1'b0; s_b = 1'b0; e_a = '0; e_b = '0; m_a = '0; m_b = '0;
        pend_exp = '0; held = '0;
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_outputs", obs_vec(), '0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        one_op("basic", 1'b0, 5, 2, 1'b0, 3, 3, {4'd6, 5'b11000, 5'b00111, 1'b0, 1'b0, 1'b1, 1'b0});
        one_op("swap",  1'b1, 2, 1, 1'b0, 5, 0, {4'd6, 5'b10000, 5'b00010, 1'b0, 1'b1, 1'b0, 1'b1});
        one_op("sat",   1'b0, 7, 0, 1'b0, 0, 3, {4'b1000, 5'b10000, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b1});
        one_op("equal", 1'b0, 4, 1, 1'b0, 4, 2, {4'd5, 5'b10100, 5'b11000, 1'b0, 1'b0, 1'b1, 1'b0});

        stream("bp", 4, 1'b0);
        stream("rnd", 24, 1'b1);

        // Two operands in flight, then an asynchronous reset between clock edges.
        out_ready = 1'b1;
        set_op(1'b0, 6, 1, 1'b1, 2, 3, model(1'b0, 6, 1, 1'b1, 2, 3));
        tick(acc);
        set_op(1'b1, 1, 2, 1'b0, 3, 1, model(1'b1, 1, 2, 1'b0, 3, 1));
        tick(acc);
        in_valid = 1'b0;
        check("mid_pipe_full", out_valid, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_outputs", obs_vec(), '0);
        check("midrst_in_ready", in_ready, 1'b1);
        sb_q.delete();
        prev_stall = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(acc);
            check("post_rst_no_out", out_valid, 1'b0);
        end
        check("post_rst_in_ready", in_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
